// File: rtl/mem_pkg.sv
// Shared definitions for the per-core requester stage in front of the 4-core shared-RAM arbiter.
package mem_pkg;

    localparam int NCORES        = 4;
    localparam int LANE_W        = 8;
    localparam int ARB_GRANT_LAT = 3;
    // The request must outlive the arbiter's registered RAM read by at least this much.
    localparam int HOLD_MIN      = ARB_GRANT_LAT - 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_HOLD    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    function automatic logic drives_strobe(input state_t s);
        return (s == ST_REQ) || (s == ST_HOLD);
    endfunction

    function automatic logic drives_lanes(input state_t s);
        return (s == ST_REQ) || (s == ST_HOLD) || (s == ST_RELEASE);
    endfunction

endpackage

// File: rtl/core_mem_port.sv
// Per-core requester: one load/store at a time, presented on the arbiter's rden/wren bit and
// byte lanes, held through the grant, then answered with a single-cycle response.
module core_mem_port
    import mem_pkg::*;
#(
    parameter int HOLD_CYCLES = 3,
    parameter int TIMEOUT     = 255,
    parameter int TO_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [LANE_W-1:0] req_addr,
    input  logic [LANE_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [LANE_W-1:0] resp_rdata,
    output logic              timeout_err,
    output logic              rden,
    output logic              wren,
    output logic [LANE_W-1:0] addr_out,
    output logic [LANE_W-1:0] din_out,
    input  logic              acq_in,
    input  logic [LANE_W-1:0] dq_in
);

    // Too short a hold would sample Dq before the arbiter's read path has settled.
    localparam int HOLD_EFF = (HOLD_CYCLES < HOLD_MIN) ? HOLD_MIN : HOLD_CYCLES;
    localparam int HC_W     = $clog2(HOLD_EFF + 1);

    state_t              state_q, state_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [HC_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic                wr_q, wr_d;
    logic [LANE_W-1:0]   cap_q, cap_d;
    logic [LANE_W-1:0]   addr_q, addr_d;
    logic [LANE_W-1:0]   din_q, din_d;
    logic                rden_q, rden_d;
    logic                wren_q, wren_d;
    logic                ready_q, ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic [LANE_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic                timeout_err_q, timeout_err_d;
    logic [TO_W-1:0]     to_cnt_inc_s;
    logic                abort_s;

    assign to_cnt_inc_s = to_cnt_q + TO_W'(1);

    // Next-state and next-output computation for every register.
    always_comb begin
        state_d    = state_q;
        to_cnt_d   = to_cnt_q;
        hold_cnt_d = hold_cnt_q;
        wr_d       = wr_q;
        cap_d      = cap_q;
        addr_d     = addr_q;
        din_d      = din_q;
        abort_s    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    state_d    = ST_REQ;
                    wr_d       = req_write;
                    addr_d     = req_addr;
                    din_d      = req_wdata;
                    to_cnt_d   = {TO_W{1'b0}};
                    hold_cnt_d = {HC_W{1'b0}};
                    cap_d      = {LANE_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                to_cnt_d = to_cnt_inc_s;
                if (acq_in) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = {HC_W{1'b0}};
                end else if (to_cnt_inc_s >= TO_W'(TIMEOUT)) begin
                    state_d = ST_RESP;
                    abort_s = 1'b1;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_HOLD: begin
                // Losing acq mid-hold means preemption; the timeout budget keeps running.
                if (!acq_in) begin
                    state_d = ST_REQ;
                end else if (hold_cnt_q == HC_W'(HOLD_EFF - 1)) begin
                    state_d = ST_RELEASE;
                    cap_d   = wr_q ? {LANE_W{1'b0}} : dq_in;
                end else begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end
            end
            ST_RELEASE: begin
                // acq is registered in the arbiter and trails our strobe drop.
                if (!acq_in) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!drives_lanes(state_d)) begin
            addr_d = {LANE_W{1'b0}};
            din_d  = {LANE_W{1'b0}};
        end else begin
            addr_d = addr_d;
            din_d  = din_d;
        end

        rden_d        = drives_strobe(state_d) & ~wr_d;
        wren_d        = drives_strobe(state_d) & wr_d;
        ready_d       = (state_d == ST_IDLE);
        resp_valid_d  = (state_d == ST_RESP);
        timeout_err_d = abort_s;
        resp_rdata_d  = ((state_d == ST_RESP) && !abort_s) ? cap_q : {LANE_W{1'b0}};
    end

    // State and registered outputs; reset clears everything, including an access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            to_cnt_q      <= {TO_W{1'b0}};
            hold_cnt_q    <= {HC_W{1'b0}};
            wr_q          <= 1'b0;
            cap_q         <= {LANE_W{1'b0}};
            addr_q        <= {LANE_W{1'b0}};
            din_q         <= {LANE_W{1'b0}};
            rden_q        <= 1'b0;
            wren_q        <= 1'b0;
            ready_q       <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= {LANE_W{1'b0}};
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            to_cnt_q      <= to_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            wr_q          <= wr_d;
            cap_q         <= cap_d;
            addr_q        <= addr_d;
            din_q         <= din_d;
            rden_q        <= rden_d;
            wren_q        <= wren_d;
            ready_q       <= ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign req_ready   = ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign timeout_err = timeout_err_q;
    assign rden        = rden_q;
    assign wren        = wren_q;
    assign addr_out    = addr_q;
    assign din_out     = din_q;

endmodule

// File: tb/tb_core_mem_port.sv
// Four requesters behind a small fixed-priority arbiter/RAM model, plus one short-timeout
// requester whose grant is tied low.
module tb_core_mem_port;

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [4:0]      req_valid, req_write, req_ready, resp_valid, timeout_err, rden, wren;
    logic [4:0][7:0] req_addr, req_wdata, resp_rdata, addr_out, din_out;

    logic [3:0]      acq_to, arb_acq, acq_s1, req_any;
    logic [3:0][7:0] dq_to, dq_r;
    logic            owner_v;
    logic [1:0]      owner;
    logic [7:0]      ram [256];
    logic            ovr, ovr_acq;
    logic [7:0]      ovr_dq;

    logic [7:0]      ref_ram [256];
    exp_t            exp_q [5][$];
    int              exp_lat [5], acc_cyc [5], acc_cnt [5], resp_cnt [5], resp_cyc [5];
    logic [7:0]      last_rdata [5];
    logic            last_err [5];
    logic [4:0]      cur_write;
    logic [4:0][7:0] cur_addr, cur_din;
    int              cyc = 0;
    int              checks = 0;
    int              errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_core
        assign acq_to[g] = (ovr && g == 0) ? ovr_acq : arb_acq[g];
        assign dq_to[g]  = (ovr && g == 0) ? ovr_dq : dq_r[g];
        core_mem_port #(.HOLD_CYCLES(3), .TIMEOUT(255), .TO_W(8)) u_dut (
            .clk(clk), .rst(rst),
            .req_valid(req_valid[g]), .req_write(req_write[g]),
            .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
            .req_ready(req_ready[g]), .resp_valid(resp_valid[g]),
            .resp_rdata(resp_rdata[g]), .timeout_err(timeout_err[g]),
            .rden(rden[g]), .wren(wren[g]),
            .addr_out(addr_out[g]), .din_out(din_out[g]),
            .acq_in(acq_to[g]), .dq_in(dq_to[g])
        );
    end

    core_mem_port #(.HOLD_CYCLES(3), .TIMEOUT(5), .TO_W(8)) u_to (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[4]), .req_write(req_write[4]),
        .req_addr(req_addr[4]), .req_wdata(req_wdata[4]),
        .req_ready(req_ready[4]), .resp_valid(resp_valid[4]),
        .resp_rdata(resp_rdata[4]), .timeout_err(timeout_err[4]),
        .rden(rden[4]), .wren(wren[4]),
        .addr_out(addr_out[4]), .din_out(din_out[4]),
        .acq_in(1'b0), .dq_in(8'h00)
    );

    assign req_any = rden[3:0] | wren[3:0];

    // Arbiter model: lowest requesting core wins, acq arrives two registers after ownership.
    always @(posedge clk) begin
        if (rst) begin
            owner_v      <= 1'b0;
            owner        <= 2'd0;
            acq_s1       <= 4'd0;
            arb_acq      <= 4'd0;
            dq_r         <= '0;
            ram[8'h12]   <= 8'hA5;
            ram[8'h20]   <= 8'h81;
            ram[8'h21]   <= 8'h42;
            ram[8'h22]   <= 8'h24;
            ram[8'h23]   <= 8'h18;
        end else begin
            acq_s1  <= owner_v ? (4'b0001 << owner) : 4'd0;
            arb_acq <= acq_s1;
            if (owner_v) begin
                if (!req_any[owner]) begin
                    owner_v <= 1'b0;
                end else begin
                    if (wren[owner]) ram[addr_out[owner]] <= din_out[owner];
                    dq_r[owner] <= ram[addr_out[owner]];
                end
            end else if (|req_any) begin
                owner_v <= 1'b1;
                owner   <= req_any[0] ? 2'd0 : req_any[1] ? 2'd1 : req_any[2] ? 2'd2 : 2'd3;
            end
        end
    end

    task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s core%0d: got %0h expected %0h", name, n, act, req);
        end
    endtask

    // Compare process: every negedge, check strobes/lanes against the outstanding request and
    // each response against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                for (int n = 0; n < 5; n++) begin
                    if (rden[n] && wren[n]) chk("rd_wr_excl", n, 32'd1, 32'd0);
                    if (rden[n]) begin
                        chk("rden_kind", n, 32'(cur_write[n]), 32'd0);
                        chk("rden_addr", n, 32'(addr_out[n]), 32'(cur_addr[n]));
                    end
                    if (wren[n]) begin
                        chk("wren_kind", n, 32'(cur_write[n]), 32'd1);
                        chk("wren_addr", n, 32'(addr_out[n]), 32'(cur_addr[n]));
                        chk("wren_din", n, 32'(din_out[n]), 32'(cur_din[n]));
                    end
                    if (req_ready[n])
                        chk("idle_quiet", n, {rden[n], wren[n], resp_valid[n], addr_out[n], din_out[n]}, 32'd0);
                    if (!resp_valid[n]) begin
                        chk("resp_idle_zero", n, {timeout_err[n], resp_rdata[n]}, 32'd0);
                    end else begin
                        resp_cnt[n]++;
                        resp_cyc[n]   = cyc;
                        last_rdata[n] = resp_rdata[n];
                        last_err[n]   = timeout_err[n];
                        if (exp_q[n].size() == 0) begin
                            chk("unexpected_resp", n, 32'(resp_cnt[n]), 32'(acc_cnt[n]));
                        end else begin
                            e = exp_q[n].pop_front();
                            chk("resp_rdata", n, 32'(resp_rdata[n]), 32'(e.rdata));
                            chk("resp_err", n, 32'(timeout_err[n]), 32'(e.err));
                            if (exp_lat[n] != 0) chk("resp_latency", n, 32'(cyc - acc_cyc[n]), 32'(exp_lat[n]));
                        end
                    end
                end
            end
        end
    end

    task automatic issue(input int n, input logic wr, input logic [7:0] a, input logic [7:0] d, input bit push);
        exp_t e;
        int t;
        req_valid[n] = 1'b1; req_write[n] = wr; req_addr[n] = a; req_wdata[n] = d;
        t = 0;
        do begin
            @(posedge clk);
            t++;
        end while (!req_ready[n] && t < 50);
        if (!req_ready[n]) begin
            chk("accept_timeout", n, 32'(t), 32'd0);
        end else begin
            acc_cyc[n] = cyc; cur_write[n] = wr; cur_addr[n] = a; cur_din[n] = d;
            if (push) begin
                if (n == 4) begin
                    e.rdata = 8'h00; e.err = 1'b1;
                end else begin
                    e.rdata = wr ? 8'h00 : ref_ram[a]; e.err = 1'b0;
                    if (wr) ref_ram[a] = d;
                end
                exp_q[n].push_back(e);
                acc_cnt[n]++;
            end
        end
        #1;
        req_valid[n] = 1'b0; req_write[n] = 1'b0; req_addr[n] = 8'h00; req_wdata[n] = 8'h00;
    endtask

    task automatic wait_resp(input int n);
        int t;
        t = 0;
        while (resp_cnt[n] < acc_cnt[n] && t < 300) begin
            @(posedge clk);
            t++;
        end
        if (resp_cnt[n] < acc_cnt[n]) chk("resp_wait_timeout", n, 32'(resp_cnt[n]), 32'(acc_cnt[n]));
        #1;
    endtask

    initial begin
        int t, base;
        exp_t e;
        rst = 1'b1; ovr = 1'b0; ovr_acq = 1'b0; ovr_dq = 8'h00;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        cur_write = '0; cur_addr = '0; cur_din = '0;
        for (int i = 0; i < 5; i++) begin
            exp_lat[i] = 0; acc_cyc[i] = 0; acc_cnt[i] = 0; resp_cnt[i] = 0; resp_cyc[i] = 0;
            last_rdata[i] = 8'h00; last_err[i] = 1'b0;
        end
        ref_ram[8'h12] = 8'hA5;
        ref_ram[8'h20] = 8'h81; ref_ram[8'h21] = 8'h42;
        ref_ram[8'h22] = 8'h24; ref_ram[8'h23] = 8'h18;

        // Reset state: every output low while rst is held; ready rises once it is released.
        repeat (3) @(posedge clk);
        #1;
        for (int n = 0; n < 5; n += 4)
            chk("reset_outputs", n, {rden[n], wren[n], req_ready[n], resp_valid[n], timeout_err[n],
                                     addr_out[n], din_out[n], resp_rdata[n]}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_reset", 0, 32'(req_ready[0]), 32'd1);

        // Single load with the arbiter free.
        exp_lat[0] = 12;
        issue(0, 1'b0, 8'h12, 8'h00, 1'b1);
        wait_resp(0);
        chk("load_a5", 0, 32'(last_rdata[0]), 32'hA5);
        chk("load_a5_err", 0, 32'(last_err[0]), 32'd0);
        exp_lat[0] = 0;

        // Store then load back.
        issue(0, 1'b1, 8'h40, 8'h3C, 1'b1);
        wait_resp(0);
        issue(0, 1'b0, 8'h40, 8'h00, 1'b1);
        wait_resp(0);
        chk("store_load_3c", 0, 32'(last_rdata[0]), 32'h3C);

        // Four cores request in the same cycle.
        fork
            issue(0, 1'b0, 8'h20, 8'h00, 1'b1);
            issue(1, 1'b0, 8'h21, 8'h00, 1'b1);
            issue(2, 1'b0, 8'h22, 8'h00, 1'b1);
            issue(3, 1'b0, 8'h23, 8'h00, 1'b1);
        join
        for (int n = 0; n < 4; n++) wait_resp(n);
        chk("contend_c3_data", 3, 32'(last_rdata[3]), 32'h18);
        for (int n = 0; n < 3; n++)
            chk("grant_order", n, 32'(resp_cyc[n] < resp_cyc[n+1]), 32'd1);

        // Grant never arrives.
        exp_lat[4] = 6;
        issue(4, 1'b0, 8'h12, 8'h00, 1'b1);
        wait_resp(4);
        chk("timeout_err", 4, 32'(last_err[4]), 32'd1);
        chk("timeout_rdata", 4, 32'(last_rdata[4]), 32'd0);
        @(posedge clk); #1;
        chk("timeout_rden_low", 4, 32'(rden[4]), 32'd0);

        // Grant stays high for four cycles after the strobe drops.
        repeat (6) @(posedge clk);
        #1;
        ovr = 1'b1; ovr_dq = 8'h77;
        issue(0, 1'b0, 8'h30, 8'h00, 1'b0);
        e.rdata = 8'h77; e.err = 1'b0;
        exp_q[0].push_back(e);
        acc_cnt[0]++;
        base = resp_cnt[0];
        ovr_acq = 1'b1;
        t = 0;
        do begin
            @(posedge clk); #1;
            t++;
        end while (rden[0] && t < 20);
        chk("stale_rden_fall", 0, 32'(rden[0]), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("stale_no_resp", 0, 32'(resp_valid[0]), 32'd0);
        end
        ovr_acq = 1'b0;
        wait_resp(0);
        repeat (5) @(posedge clk);
        #1;
        chk("stale_one_resp", 0, 32'(resp_cnt[0] - base), 32'd1);

        // Reset while holding a granted load.
        issue(0, 1'b0, 8'h31, 8'h00, 1'b0);
        ovr_acq = 1'b1;
        @(posedge clk); #1;
        chk("hold_rden_high", 0, 32'(rden[0]), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_hold_strobes", 0, {rden[0], wren[0], resp_valid[0]}, 32'd0);
        rst = 1'b0; ovr_acq = 1'b0;
        @(posedge clk); #1;
        chk("rst_hold_ready", 0, 32'(req_ready[0]), 32'd1);
        ovr = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        for (int n = 0; n < 5; n++) chk("scoreboard_empty", n, 32'(exp_q[n].size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
